// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the boot-time memory loader.
// Holds the loader state encoding, default widths and the checksum accumulator.
package mem_loader_pkg;

    localparam int DEF_W  = 32;
    localparam int CSUM_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Wrapping checksum accumulation of one accepted word.
    function automatic logic [CSUM_W-1:0] csum_add(
        input logic [CSUM_W-1:0] acc,
        input logic [CSUM_W-1:0] word
    );
        csum_add = acc + word;
    endfunction

endpackage

// File: rtl/mem_loader_counter.sv
// Remaining-word down-counter paired with the write-address up-counter.
// The address parks on the final word so it can never reach N.
module load_counter
    import mem_loader_pkg::*;
#(
    parameter int N  = 64,
    parameter int AW = $clog2(N),
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] load_len,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          zero
);

    logic [LW-1:0] remaining_r;
    logic [AW-1:0] addr_r;
    logic          last_s;
    logic          zero_s;

    assign last_s = (remaining_r == LW'(1));
    assign zero_s = (remaining_r == {LW{1'b0}});

    // Load both counters on start; advance them once per accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r <= {LW{1'b0}};
            addr_r      <= {AW{1'b0}};
        end else if (load) begin
            remaining_r <= load_len;
            addr_r      <= {AW{1'b0}};
        end else if (step && !zero_s) begin
            remaining_r <= remaining_r - LW'(1);
            if (!last_s) begin
                addr_r <= addr_r + AW'(1);
            end
        end
    end

    assign addr = addr_r;
    assign last = last_s;
    assign zero = zero_s;

endmodule

// File: rtl/mem_loader.sv
// Streams firmware words into consecutive memory addresses through a registered
// write port, keeping a wrapping checksum and done/error/abort status pulses.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter  int N  = 64,
    parameter  int W  = DEF_W,
    localparam int AW = $clog2(N),
    localparam int LW = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LW-1:0]     length,
    input  logic              abort,
    input  logic [W-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [W-1:0]      wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted,
    output logic [CSUM_W-1:0] checksum
);

    state_e state_r;
    state_e next_s;

    logic in_ready_s;
    logic accept_s;
    logic load_s;
    logic clear_csum_s;
    logic len_err_s;
    logic abort_s;

    logic [AW-1:0] cnt_addr_s;
    logic          cnt_last_s;
    logic          cnt_zero_s;

    logic              wr_en_r;
    logic [AW-1:0]     wr_addr_r;
    logic [W-1:0]      wr_data_r;
    logic              error_r;
    logic              aborted_r;
    logic [CSUM_W-1:0] checksum_r;

    load_counter #(
        .N  (N),
        .AW (AW),
        .LW (LW)
    ) u_load_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_len (length),
        .step     (accept_s),
        .addr     (cnt_addr_s),
        .last     (cnt_last_s),
        .zero     (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode and handshake; abort outranks a word arriving in the same cycle.
    always_comb begin
        next_s       = state_r;
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        load_s       = 1'b0;
        clear_csum_s = 1'b0;
        len_err_s    = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length == {LW{1'b0}}) begin
                        next_s       = DONE;
                        clear_csum_s = 1'b1;
                    end else if (length <= LW'(N)) begin
                        next_s       = LOAD;
                        load_s       = 1'b1;
                        clear_csum_s = 1'b1;
                    end else begin
                        next_s    = IDLE;
                        len_err_s = 1'b1;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: begin
                in_ready_s = 1'b1;
                if (cnt_zero_s) begin
                    // Nothing left to load can only mean corrupted state: refuse words and recover.
                    in_ready_s = 1'b0;
                    next_s     = IDLE;
                end else if (abort) begin
                    abort_s = 1'b1;
                    next_s  = IDLE;
                end else if (in_valid) begin
                    accept_s = 1'b1;
                    if (cnt_last_s) begin
                        next_s = DONE;
                    end else begin
                        next_s = LOAD;
                    end
                end else begin
                    next_s = LOAD;
                end
            end
            DONE: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Registered write port, status pulses and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {AW{1'b0}};
            wr_data_r  <= {W{1'b0}};
            error_r    <= 1'b0;
            aborted_r  <= 1'b0;
            checksum_r <= {CSUM_W{1'b0}};
        end else begin
            wr_en_r   <= accept_s;
            error_r   <= len_err_s;
            aborted_r <= abort_s;
            if (accept_s) begin
                wr_addr_r <= cnt_addr_s;
                wr_data_r <= in_data;
            end
            if (clear_csum_s) begin
                checksum_r <= {CSUM_W{1'b0}};
            end else if (accept_s) begin
                checksum_r <= csum_add(checksum_r, CSUM_W'(in_data));
            end
        end
    end

    assign in_ready = in_ready_s;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = (state_r == LOAD) || (state_r == DONE);
    assign done     = (state_r == DONE);
    assign error    = error_r;
    assign aborted  = aborted_r;
    assign checksum = checksum_r;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a transaction-level model predicts every
// output each cycle while directed and random loads are streamed in.
module tb_mem_loader;

    localparam int N  = 64;
    localparam int AW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort, in_valid;
    logic [LW-1:0] length;
    logic [31:0]   in_data;
    logic          in_ready, wr_en, busy, done, error, aborted;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data, checksum;

    always #5 clk = ~clk;

    mem_loader #(.N(N), .W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .error(error), .aborted(aborted), .checksum(checksum)
    );

    int checks = 0;
    int errors = 0;

    // Model state: expected outputs after each rising edge.
    bit            model_valid = 1'b0;
    bit            m_loading = 1'b0;
    int            m_left = 0;
    int            m_addr = 0;
    int            acc_total = 0;
    logic          e_wr_en = 1'b0, e_done = 1'b0, e_error = 1'b0, e_aborted = 1'b0;
    logic [AW-1:0] e_wr_addr = '0;
    logic [31:0]   e_wr_data = 32'd0, e_checksum = 32'd0;

    logic [31:0]   words [0:127];
    int            vq[$];
    int            n_wr = 0, n_done = 0, n_err = 0, n_abt = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; n_err = 0; n_abt = 0;
    endtask

    // Behavioural model: a load is just "accept length words, write word k to address k".
    always @(posedge clk) begin : model
        bit was_done;
        if (rst) begin
            m_loading = 1'b0; m_left = 0; m_addr = 0;
            e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = 32'd0;
            e_done = 1'b0; e_error = 1'b0; e_aborted = 1'b0; e_checksum = 32'd0;
        end else begin
            was_done  = e_done;
            e_wr_en   = 1'b0;
            e_done    = 1'b0;
            e_error   = 1'b0;
            e_aborted = 1'b0;
            if (m_loading) begin
                if (abort) begin
                    m_loading = 1'b0;
                    e_aborted = 1'b1;
                end else if (in_valid) begin
                    e_wr_en    = 1'b1;
                    e_wr_addr  = AW'(m_addr);
                    e_wr_data  = in_data;
                    e_checksum = e_checksum + in_data;
                    m_addr++;
                    m_left--;
                    acc_total++;
                    if (m_left == 0) begin
                        m_loading = 1'b0;
                        e_done    = 1'b1;
                    end
                end
            end else if (!was_done && start) begin
                if (length > N) begin
                    e_error = 1'b1;
                end else begin
                    e_checksum = 32'd0;
                    if (length == 0) begin
                        e_done = 1'b1;
                    end else begin
                        m_loading = 1'b1;
                        m_left    = length;
                        m_addr    = 0;
                    end
                end
            end
        end
        model_valid = 1'b1;
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("wr_en", wr_en, e_wr_en);
            chk("wr_addr", wr_addr, e_wr_addr);
            chk("wr_data", wr_data, e_wr_data);
            chk("done", done, e_done);
            chk("error", error, e_error);
            chk("aborted", aborted, e_aborted);
            chk("checksum", checksum, e_checksum);
            chk("in_ready", in_ready, m_loading);
            chk("busy", busy, m_loading || e_done);
            if (wr_en === 1'b1) begin
                n_wr++;
                last_addr = wr_addr;
            end
            if (done === 1'b1) n_done++;
            if (error === 1'b1) n_err++;
            if (aborted === 1'b1) n_abt++;
        end
    end

    // Issue one start, then feed words[] until the model says the load has ended.
    task automatic run_load(input int len, input int vprob, input int abort_at);
        int base;
        int budget;
        int idx;
        bit v;
        length = LW'(len);
        start  = 1'b1;
        step();
        start  = 1'b0;
        base   = acc_total;
        budget = len * 40 + 20;
        while (m_loading && budget > 0) begin
            idx = acc_total - base;
            if (vq.size() > 0) v = vq.pop_front();
            else v = ($urandom_range(99) < vprob);
            in_valid = v;
            in_data  = v ? words[idx] : $urandom;
            abort    = (abort_at >= 0) && (idx == abort_at) && v;
            start    = ($urandom_range(15) == 0);
            step();
            budget--;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("load_finished", m_loading, 1'b0);
        start = e_done ? 1'($urandom_range(1)) : 1'b0;
        step();
        start = 1'b0;
        vq.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        length = '0; in_data = 32'd0;
        repeat (3) step();
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_csum", checksum, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        step();

        // Basic load with in_valid held high.
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        clear_counts();
        run_load(4, 100, -1);
        chk("basic_nwr", n_wr, 4);
        chk("basic_last_addr", last_addr, 3);
        chk("basic_done", n_done, 1);
        chk("basic_csum", checksum, 32'hAA);
        chk("basic_model_csum", e_checksum, 32'hAA);

        // Stalled stream.
        words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
        clear_counts();
        vq = '{1, 0, 0, 1, 0, 1};
        run_load(3, 0, -1);
        chk("stall_nwr", n_wr, 3);
        chk("stall_last_addr", last_addr, 2);
        chk("stall_done", n_done, 1);

        // Full depth.
        for (int i = 0; i < 64; i++) words[i] = i;
        clear_counts();
        run_load(64, 100, -1);
        chk("full_nwr", n_wr, 64);
        chk("full_last_addr", last_addr, 63);
        chk("full_csum", checksum, 32'd2016);

        // Over-length start is rejected.
        clear_counts();
        run_load(65, 100, -1);
        chk("len65_err", n_err, 1);
        chk("len65_nwr", n_wr, 0);
        chk("len65_busy", busy, 1'b0);
        chk("len65_csum", checksum, 32'd2016);

        // Zero-length load.
        clear_counts();
        run_load(0, 100, -1);
        chk("len0_done", n_done, 1);
        chk("len0_nwr", n_wr, 0);
        chk("len0_csum", checksum, 32'd0);

        // Abort on the third word.
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        clear_counts();
        run_load(8, 100, 2);
        chk("abort_nwr", n_wr, 2);
        chk("abort_last_addr", last_addr, 1);
        chk("abort_pulse", n_abt, 1);
        chk("abort_no_done", n_done, 0);
        chk("abort_in_ready", in_ready, 1'b0);

        // Reset in the middle of a load.
        clear_counts();
        length = LW'(8); start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; step();
        in_data = 32'h6; step();
        in_valid = 1'b0; rst = 1'b1; step();
        chk("mid_rst_wr_en", wr_en, 1'b0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_csum", checksum, 32'd0);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        step(); step();
        chk("mid_rst_no_done", n_done, 0);
        words[0] = 32'hFFFFFFFF;
        clear_counts();
        run_load(1, 100, -1);
        chk("after_rst_nwr", n_wr, 1);
        chk("after_rst_addr", last_addr, 0);
        chk("after_rst_csum", checksum, 32'hFFFFFFFF);

        // Checksum wraps modulo 2^32.
        words[0] = 32'hFFFFFFFF; words[1] = 32'h00000002;
        run_load(2, 100, -1);
        chk("wrap_csum", checksum, 32'h00000001);

        // Random loads: lengths past the bound, stalls, aborts and stray starts.
        for (int t = 0; t < 40; t++) begin
            int len;
            int ab;
            len = $urandom_range(70);
            for (int i = 0; i < 128; i++) words[i] = $urandom;
            ab = ($urandom_range(4) == 0 && len > 0) ? int'($urandom_range(len - 1)) : -1;
            run_load(len, $urandom_range(100, 20), ab);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
